irq_controller: RTL

//  Memory-mapped interrupt controller that drives the CPU's active-low nIRQ input.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_src_cell.sv | 45 ++++
 rtl/irq_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, default
// geometry and the lowest-index priority encoder used for the VECTOR register.
package irq_pkg;

    localparam int          DEFAULT_NUM_SRC   = 8;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    localparam logic [7:0] OFS_STATUS  = 8'h00;
    localparam logic [7:0] OFS_ENABLE  = 8'h04;
    localparam logic [7:0] OFS_PENDING = 8'h08;
    localparam logic [7:0] OFS_CLEAR   = 8'h0C;
    localparam logic [7:0] OFS_EDGE    = 8'h10;
    localparam logic [7:0] OFS_VECTOR  = 8'h14;

    // Returns {valid, index}; scanning downward leaves the lowest set index.
    function automatic logic [5:0] prio_enc(input logic [31:0] vec);
        logic [5:0] res;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, 5'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: input sampling flop, rising-edge detect and the
// pending flop, which either latches edges (W1C) or follows the line (level).
module irq_src_cell
(
    input  logic clk,
    input  logic reset,
    input  logic src_irq,
    input  logic edge_mode,
    input  logic clr,
    output logic pending
);

    logic src_q_q;
    logic src_q_d;
    logic pending_q;
    logic pending_d;

    always_comb begin
        src_q_d   = src_irq;
        pending_d = pending_q;
        if (edge_mode) begin
            // A new edge on the same cycle as a clear must not be lost.
            if (src_irq && !src_q_q) begin
                pending_d = 1'b1;
            end else if (clr) begin
                pending_d = 1'b0;
            end
        end else begin
            pending_d = src_irq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            src_q_q   <= src_q_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: register file, byte-lane writes,
// registered read data and the registered active-low nIRQ output.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = DEFAULT_NUM_SRC,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [31:0]        memaddr,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [3:0]         be,
    input  logic [31:0]        writedata,
    output logic               hit,
    output logic [31:0]        rdata,
    output logic               nIRQ
);

    // Bus: a transfer happens on every clk edge where its strobe and hit are
    // both high; there is no stall, reads return data one cycle later.
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               nirq_q, nirq_d;

    logic [NUM_SRC-1:0] pending;
    logic [7:0]         ofs;
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        lane_mask;
    logic [31:0]        en_ext, edge_ext, pend_ext, status_ext;
    logic [31:0]        en_wr, edge_wr, clr_ext;
    logic [5:0]         prio;
    logic               unused_bits;

    assign hit   = (memaddr[31:8] == BASE_ADDR[31:8]);
    assign ofs   = {memaddr[7:2], 2'b00};
    assign wr_en = memwrite && hit;
    assign rd_en = memread && hit;

    always_comb begin
        en_ext     = '0;
        edge_ext   = '0;
        pend_ext   = '0;
        en_ext[NUM_SRC-1:0]   = enable_q;
        edge_ext[NUM_SRC-1:0] = edge_q;
        pend_ext[NUM_SRC-1:0] = pending;
        status_ext = pend_ext & en_ext;
        for (int n = 0; n < 4; n++) begin
            lane_mask[8*n +: 8] = {8{be[n]}};
        end
        en_wr   = (writedata & lane_mask) | (en_ext & ~lane_mask);
        edge_wr = (writedata & lane_mask) | (edge_ext & ~lane_mask);
        clr_ext = (wr_en && ofs == OFS_CLEAR) ? (writedata & lane_mask) : '0;
        prio    = prio_enc(status_ext);
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        if (wr_en && ofs == OFS_ENABLE) begin
            enable_d = en_wr[NUM_SRC-1:0];
        end
        if (wr_en && ofs == OFS_EDGE) begin
            edge_d = edge_wr[NUM_SRC-1:0];
        end
    end

    // Read mux sees pre-edge register state, so a same-edge write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (ofs)
                OFS_STATUS:  rdata_d = status_ext;
                OFS_ENABLE:  rdata_d = en_ext;
                OFS_PENDING: rdata_d = pend_ext;
                OFS_EDGE:    rdata_d = edge_ext;
                OFS_VECTOR:  rdata_d = {prio[5], 26'b0, prio[4:0]};
                default:     rdata_d = '0;
            endcase
        end
        nirq_d = ~|status_ext;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_src_cell u_cell (
                .clk       (clk),
                .reset     (reset),
                .src_irq   (src_irq[gi]),
                .edge_mode (edge_q[gi]),
                .clr       (clr_ext[gi]),
                .pending   (pending[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= '0;
            edge_q   <= '0;
            rdata_q  <= '0;
            nirq_q   <= 1'b1;
        end else begin
            enable_q <= enable_d;
            edge_q   <= edge_d;
            rdata_q  <= rdata_d;
            nirq_q   <= nirq_d;
        end
    end

    assign rdata = rdata_q;
    assign nIRQ  = nirq_q;

    // Address bits [1:0] and lane bits above NUM_SRC carry no state.
    assign unused_bits = ^{memaddr[1:0], en_wr, edge_wr, clr_ext};

endmodule
